// File: rtl/bit_serializer_pkg.sv
// bit_serializer_pkg: state type and default word width shared by the serializer.
package bit_serializer_pkg;
   typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t;
   localparam int SER_W_DEFAULT = 8;
endpackage

// File: rtl/bit_serializer.sv
// bit_serializer: accepts W-bit words on valid/ready and emits one bit per clock.
// Define BIT_SERIALIZER_GAPLESS_EN to accept the next word on the last bit, removing the idle gap.
module bit_serializer
   import bit_serializer_pkg::*;
#(
   parameter int W         = SER_W_DEFAULT,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   input  logic         din_valid,
   output logic         din_ready,
   output logic         bit_out,
   output logic         bit_valid,
   output logic         word_done,
   output logic         busy
);
   localparam int CW = $clog2(W);
   localparam logic [CW-1:0] LAST = CW'(W - 1);
   ser_state_t   state;
   logic [W-1:0] sr;
   logic [CW-1:0] cnt;
   logic         last;
   logic         accept;
   assign last = (state == SER_SHIFT) && (cnt == LAST);
`ifdef BIT_SERIALIZER_GAPLESS_EN
   assign din_ready = !rst && ((state == SER_IDLE) || last);
`else
   assign din_ready = !rst && (state == SER_IDLE);
`endif
   assign accept = din_valid && din_ready;
   assign busy   = (state == SER_SHIFT);
   // sr holds the untransmitted tail; bit_out always shows the bit at the leading end
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= SER_IDLE;
         sr        <= '0;
         cnt       <= '0;
         bit_out   <= 1'b0;
         bit_valid <= 1'b0;
         word_done <= 1'b0;
      end else if (accept) begin
         state     <= SER_SHIFT;
         sr        <= din;
         cnt       <= '0;
         bit_out   <= MSB_FIRST ? din[W-1] : din[0];
         bit_valid <= 1'b1;
         word_done <= 1'b0;
      end else if (last) begin
         state     <= SER_IDLE;
         bit_out   <= 1'b0;
         bit_valid <= 1'b0;
         word_done <= 1'b0;
      end else if (state == SER_SHIFT) begin
         sr        <= MSB_FIRST ? (sr << 1) : (sr >> 1);
         cnt       <= cnt + 1'b1;
         bit_out   <= MSB_FIRST ? sr[W-2] : sr[1];
         word_done <= (cnt == LAST - 1'b1);
      end
   end
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: directed checks of an MSB-first and an LSB-first 8-bit serializer.
module tb_bit_serializer;
   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din_a, din_b;
   logic       valid_a, valid_b;
   logic       ready_a, bit_a, bv_a, wd_a, busy_a;
   logic       ready_b, bit_b, bv_b, wd_b, busy_b;
   int         n_vec = 0;
   int         n_err = 0;
`ifdef BIT_SERIALIZER_GAPLESS_EN
   localparam bit GL = 1'b1;
`else
   localparam bit GL = 1'b0;
`endif

   always #5 clk = ~clk;

   bit_serializer #(.W(8), .MSB_FIRST(1'b1)) dut_a (
      .clk(clk), .rst(rst), .din(din_a), .din_valid(valid_a), .din_ready(ready_a),
      .bit_out(bit_a), .bit_valid(bv_a), .word_done(wd_a), .busy(busy_a));

   bit_serializer #(.W(8), .MSB_FIRST(1'b0)) dut_b (
      .clk(clk), .rst(rst), .din(din_b), .din_valid(valid_b), .din_ready(ready_b),
      .bit_out(bit_b), .bit_valid(bv_b), .word_done(wd_b), .busy(busy_b));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_bv"}, bv_a, 0);
      chk({tag, "_bit"}, bit_a, 0);
      chk({tag, "_busy"}, busy_a, 0);
      chk({tag, "_done"}, wd_a, 0);
   endtask

   // drive one word at a negedge; returns at the negedge showing bit 0
   task automatic send_a(input logic [7:0] w);
      din_a   = w;
      valid_a = 1'b1;
      @(negedge clk);
      valid_a = 1'b0;
   endtask

   task automatic expect_a(input logic [7:0] w, input string tag);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("%s_bit%0d", tag, i), bit_a, w[7-i]);
         chk($sformatf("%s_bv%0d", tag, i), bv_a, 1);
         chk($sformatf("%s_done%0d", tag, i), wd_a, i == 7);
         chk($sformatf("%s_rdy%0d", tag, i), ready_a, GL && i == 7);
         chk($sformatf("%s_busy%0d", tag, i), busy_a, 1);
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] lsb_exp;
      logic [2:0] hist;
      int         hits, hit_i;
      rst = 1'b1; din_a = '0; din_b = '0; valid_a = 1'b0; valid_b = 1'b0;
      @(negedge clk);
      chk("rst_ready", ready_a, 0);
      chk_idle("rst");
      valid_a = 1'b1; din_a = 8'hFF;
      @(negedge clk);
      chk("rst_valid_ignored", bv_a, 0);
      valid_a = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", ready_a, 1);
      chk_idle("post_rst");

      send_a(8'hA5);
      expect_a(8'hA5, "basic");
      chk_idle("basic_end");
      chk("basic_end_rdy", ready_a, 1);

      send_a(8'hA5);
      for (int i = 0; i < 8; i++) begin
         din_a   = (i == 3) ? 8'h3C : 8'hA5;
         valid_a = (i == 3);
         chk($sformatf("ign_bit%0d", i), bit_a, 8'hA5 >> (7 - i) & 1);
         chk($sformatf("ign_bv%0d", i), bv_a, 1);
         @(negedge clk);
      end
      valid_a = 1'b0;
      chk_idle("ign_end");
      @(negedge clk);
      chk_idle("ign_no3c");

      send_a(8'hA5);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("mid_bit%0d", i), bit_a, 8'hA5 >> (7 - i) & 1);
         if (i < 2) @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      chk_idle("mid_rst");
      chk("mid_rst_rdy", ready_a, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_post_rdy", ready_a, 1);
      chk_idle("mid_post");
      send_a(8'h81);
      expect_a(8'h81, "w81");

      din_a   = 8'hFF;
      valid_a = 1'b1;
      @(negedge clk);
      din_a = 8'h00;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("b2b_ff_bit%0d", i), bit_a, 1);
         chk($sformatf("b2b_ff_bv%0d", i), bv_a, 1);
         chk($sformatf("b2b_ff_done%0d", i), wd_a, i == 7);
         @(negedge clk);
      end
      if (!GL) begin
         chk("b2b_gap_bv", bv_a, 0);
         chk("b2b_gap_rdy", ready_a, 1);
         @(negedge clk);
      end
      valid_a = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("b2b_00_bit%0d", i), bit_a, 0);
         chk($sformatf("b2b_00_bv%0d", i), bv_a, 1);
         chk($sformatf("b2b_00_done%0d", i), wd_a, i == 7);
         @(negedge clk);
      end
      chk_idle("b2b_end");

      lsb_exp = 8'b0000_0101;
      hist = 3'b000; hits = 0; hit_i = -1;
      din_b = 8'h05; valid_b = 1'b1;
      @(negedge clk);
      valid_b = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("lsb_bit%0d", i), bit_b, lsb_exp[i]);
         chk($sformatf("lsb_bv%0d", i), bv_b, 1);
         chk($sformatf("lsb_done%0d", i), wd_b, i == 7);
         hist = {hist[1:0], bit_b};
         if (hist == 3'b101) begin
            hits++;
            hit_i = i;
         end
         @(negedge clk);
      end
      chk("lsb_det_hits", hits, 1);
      chk("lsb_det_pos", hit_i, 2);
      chk("lsb_end_bv", bv_b, 0);
      chk("lsb_end_busy", busy_b, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
